// File: rtl/execute_cc_stage.sv
// Y86-64 execute-stage back end: condition-code register, jXX/cmovXX condition
// evaluation and the E/M pipeline register with stall/bubble control.
module execute_cc_stage #(
    parameter int BUS_WIDTH    = 64,
    parameter int REG_ID_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    e_valid,
    input  logic [3:0]              e_icode,
    input  logic [3:0]              e_ifun,
    input  logic [REG_ID_WIDTH-1:0] e_dst_e,
    input  logic [BUS_WIDTH-1:0]    e_val_a,
    input  logic [BUS_WIDTH-1:0]    alu_result,
    input  logic                    alu_overflow,
    input  logic                    cc_block,
    input  logic                    stall,
    input  logic                    bubble,
    output logic                    zf,
    output logic                    sf,
    output logic                    of,
    output logic                    e_cnd,
    output logic                    m_valid,
    output logic [3:0]              m_icode,
    output logic                    m_cnd,
    output logic [REG_ID_WIDTH-1:0] m_dst_e,
    output logic [BUS_WIDTH-1:0]    m_val_e,
    output logic [BUS_WIDTH-1:0]    m_val_a
);

    localparam logic [3:0]              I_NOP    = 4'h1;
    localparam logic [3:0]              I_RRMOVQ = 4'h2;
    localparam logic [3:0]              I_OPQ    = 4'h6;
    localparam logic [3:0]              I_JXX    = 4'h7;
    localparam logic [REG_ID_WIDTH-1:0] RNONE    = '1;

    logic                    r_zf, r_sf, r_of;
    logic                    r_m_valid;
    logic [3:0]              r_m_icode;
    logic                    r_m_cnd;
    logic [REG_ID_WIDTH-1:0] r_m_dst_e;
    logic [BUS_WIDTH-1:0]    r_m_val_e;
    logic [BUS_WIDTH-1:0]    r_m_val_a;

    logic                    w_cnd;
    logic                    w_cnd_eff;
    logic [REG_ID_WIDTH-1:0] w_dst_eff;
    logic                    w_cc_we;

    // Condition is taken from the CC register as it stands; no forwarding of
    // the flags an OPq in the same cycle is about to write.
    always_comb begin
        // NOTE: default assignment first so every path drives w_cnd; no latch.
        w_cnd = 1'b0;
        case (e_ifun)
            4'h0:    w_cnd = 1'b1;
            4'h1:    w_cnd = (r_sf ^ r_of) | r_zf;
            4'h2:    w_cnd = r_sf ^ r_of;
            4'h3:    w_cnd = r_zf;
            4'h4:    w_cnd = ~r_zf;
            4'h5:    w_cnd = ~(r_sf ^ r_of);
            4'h6:    w_cnd = ~(r_sf ^ r_of) & ~r_zf;
            default: w_cnd = 1'b0;
        endcase
    end

    assign w_cnd_eff = ((e_icode == I_RRMOVQ) || (e_icode == I_JXX)) ? w_cnd : 1'b0;
    assign w_dst_eff = ((e_icode == I_RRMOVQ) && !w_cnd) ? RNONE : e_dst_e;
    assign w_cc_we   = !stall && e_valid && (e_icode == I_OPQ) && !cc_block;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments for all registered state.
            r_zf      <= 1'b1;
            r_sf      <= 1'b0;
            r_of      <= 1'b0;
            r_m_valid <= 1'b0;
            r_m_icode <= I_NOP;
            r_m_cnd   <= 1'b0;
            r_m_dst_e <= RNONE;
            r_m_val_e <= '0;
            r_m_val_a <= '0;
        end else begin
            if (w_cc_we) begin
                r_zf <= (alu_result == '0);
                r_sf <= alu_result[BUS_WIDTH-1];
                r_of <= alu_overflow;
            end
            if (!stall) begin
                if (bubble || !e_valid) begin
                    r_m_valid <= 1'b0;
                    r_m_icode <= I_NOP;
                    r_m_cnd   <= 1'b0;
                    r_m_dst_e <= RNONE;
                    r_m_val_e <= '0;
                    r_m_val_a <= '0;
                end else begin
                    r_m_valid <= 1'b1;
                    r_m_icode <= e_icode;
                    r_m_cnd   <= w_cnd_eff;
                    r_m_dst_e <= w_dst_eff;
                    r_m_val_e <= alu_result;
                    r_m_val_a <= e_val_a;
                end
            end
        end
    end

    assign zf      = r_zf;
    assign sf      = r_sf;
    assign of      = r_of;
    assign e_cnd   = w_cnd;
    assign m_valid = r_m_valid;
    assign m_icode = r_m_icode;
    assign m_cnd   = r_m_cnd;
    assign m_dst_e = r_m_dst_e;
    assign m_val_e = r_m_val_e;
    assign m_val_a = r_m_val_a;

endmodule

// File: tb/tb_execute_cc_stage.sv
// Scoreboard bench for execute_cc_stage: directed plan items then random traffic,
// checked against a flag/pipeline reference model.
module tb_execute_cc_stage;

    typedef struct packed {
        logic        rst;
        logic        valid;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  dst;
        logic [63:0] val_a;
        logic [63:0] res;
        logic        ovf;
        logic        blk;
        logic        stall;
        logic        bubble;
    } stim_t;

    typedef struct packed {
        logic        zf, sf, of;
        logic        valid;
        logic [3:0]  icode;
        logic        cnd;
        logic [3:0]  dst;
        logic [63:0] val_e;
        logic [63:0] val_a;
    } state_t;

    logic clk = 1'b0;
    logic rst, e_valid, alu_overflow, cc_block, stall, bubble;
    logic [3:0]  e_icode, e_ifun, e_dst_e;
    logic [63:0] e_val_a, alu_result;
    logic zf, sf, of, e_cnd, m_valid, m_cnd;
    logic [3:0]  m_icode, m_dst_e;
    logic [63:0] m_val_e, m_val_a;

    int n_tests = 0;
    int n_fail  = 0;

    state_t model;
    bit     cc_known = 1'b0;
    logic   q_cnd[$];
    state_t q_state[$];

    always #5 clk = ~clk;

    execute_cc_stage dut (
        .clk(clk), .rst(rst), .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun),
        .e_dst_e(e_dst_e), .e_val_a(e_val_a), .alu_result(alu_result),
        .alu_overflow(alu_overflow), .cc_block(cc_block), .stall(stall), .bubble(bubble),
        .zf(zf), .sf(sf), .of(of), .e_cnd(e_cnd), .m_valid(m_valid), .m_icode(m_icode),
        .m_cnd(m_cnd), .m_dst_e(m_dst_e), .m_val_e(m_val_e), .m_val_a(m_val_a)
    );

    // Condition truth from the flags: "less" is signed-less-than, "eq" is zero.
    function automatic logic cond_of(input logic [3:0] ifun, input logic z, s, o);
        logic less, eq;
        less = (s != o);
        eq   = z;
        case (ifun)
            4'd0:    return 1'b1;
            4'd1:    return less || eq;
            4'd2:    return less;
            4'd3:    return eq;
            4'd4:    return !eq;
            4'd5:    return !less;
            4'd6:    return !less && !eq;
            default: return 1'b0;
        endcase
    endfunction

    function automatic state_t nop_state(input state_t cur);
        state_t n = cur;
        n.valid = 1'b0; n.icode = 4'd1; n.cnd = 1'b0; n.dst = 4'hF;
        n.val_e = '0;   n.val_a = '0;
        return n;
    endfunction

    task automatic step(input stim_t s);
        logic c;
        state_t nxt;
        @(posedge clk);
        #2;
        rst = s.rst; e_valid = s.valid; e_icode = s.icode; e_ifun = s.ifun;
        e_dst_e = s.dst; e_val_a = s.val_a; alu_result = s.res; alu_overflow = s.ovf;
        cc_block = s.blk; stall = s.stall; bubble = s.bubble;
        c = cond_of(s.ifun, model.zf, model.sf, model.of);
        if (cc_known) q_cnd.push_back(c);
        nxt = model;
        if (s.rst) begin
            nxt = nop_state(model);
            nxt.zf = 1'b1; nxt.sf = 1'b0; nxt.of = 1'b0;
            cc_known = 1'b1;
        end else begin
            if (!s.stall && s.valid && s.icode == 4'd6 && !s.blk) begin
                nxt.zf = (s.res == 64'd0);
                nxt.sf = s.res[63];
                nxt.of = s.ovf;
            end
            if (!s.stall) begin
                if (s.bubble || !s.valid) begin
                    nxt = nop_state(nxt);
                end else begin
                    nxt.valid = 1'b1;
                    nxt.icode = s.icode;
                    nxt.cnd   = (s.icode == 4'd2 || s.icode == 4'd7) ? c : 1'b0;
                    nxt.dst   = (s.icode == 4'd2 && !c) ? 4'hF : s.dst;
                    nxt.val_e = s.res;
                    nxt.val_a = s.val_a;
                end
            end
        end
        model = nxt;
        if (cc_known) q_state.push_back(nxt);
    endtask

    function automatic stim_t mk(input logic r, v, input logic [3:0] ic, fn, d,
                                 input logic [63:0] res, input logic ov, blk, st, bb);
        stim_t s;
        s.rst = r; s.valid = v; s.icode = ic; s.ifun = fn; s.dst = d;
        s.val_a = 64'hA5A5_0000_0000_0000 | 64'(fn) | (64'(ic) << 8);
        s.res = res; s.ovf = ov; s.blk = blk; s.stall = st; s.bubble = bb;
        return s;
    endfunction

    // Monitor: e_cnd checked mid-cycle, registered state checked after the edge.
    initial begin : monitor
        logic   exp_c;
        state_t exp_s, act_s;
        forever begin
            @(negedge clk);
            if (q_cnd.size() > 0) begin
                exp_c = q_cnd.pop_front();
                n_tests++;
                if (e_cnd !== exp_c) begin
                    n_fail++;
                    $display("FAIL e_cnd @%0t: got %b expected %b", $time, e_cnd, exp_c);
                end
            end
            @(posedge clk);
            #1;
            if (q_state.size() > 0) begin
                exp_s = q_state.pop_front();
                act_s = {zf, sf, of, m_valid, m_icode, m_cnd, m_dst_e, m_val_e, m_val_a};
                n_tests++;
                if (act_s !== exp_s) begin
                    n_fail++;
                    $display("FAIL state @%0t: got zso=%b%b%b v=%b ic=%h c=%b d=%h ve=%h va=%h expected zso=%b%b%b v=%b ic=%h c=%b d=%h ve=%h va=%h",
                             $time, act_s.zf, act_s.sf, act_s.of, act_s.valid, act_s.icode, act_s.cnd,
                             act_s.dst, act_s.val_e, act_s.val_a, exp_s.zf, exp_s.sf, exp_s.of,
                             exp_s.valid, exp_s.icode, exp_s.cnd, exp_s.dst, exp_s.val_e, exp_s.val_a);
                end
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        rst = 1'b1; e_valid = 0; e_icode = 4'd1; e_ifun = 0; e_dst_e = 4'hF;
        e_val_a = '0; alu_result = '0; alu_overflow = 0; cc_block = 0; stall = 0; bubble = 0;
        model = '0;

        // Reset for two cycles.
        repeat (2) step(mk(1, 0, 4'd1, 0, 4'hF, 64'd0, 0, 0, 0, 0));
        // OPq flag capture: zero result, then MSB-set with overflow.
        step(mk(0, 1, 4'd6, 4'd1, 4'd2, 64'd0, 0, 0, 0, 0));
        step(mk(0, 1, 4'd6, 4'd0, 4'd2, 64'h8000_0000_0000_0000, 1, 0, 0, 0));
        // Preload sf=1 of=0 zf=0, then sweep jXX conditions 0..6.
        step(mk(0, 1, 4'd6, 4'd0, 4'd4, 64'h8000_0000_0000_0000, 0, 0, 0, 0));
        for (int f = 0; f < 7; f++) step(mk(0, 1, 4'd7, 4'(f), 4'hF, 64'h100, 0, 0, 0, 0));
        // cmov equal with zf=0 (not taken), then with zf=1 (taken).
        step(mk(0, 1, 4'd2, 4'd3, 4'd3, 64'h55, 0, 0, 0, 0));
        step(mk(0, 1, 4'd6, 4'd1, 4'd5, 64'd0, 0, 0, 0, 0));
        step(mk(0, 1, 4'd2, 4'd3, 4'd3, 64'h66, 0, 0, 0, 0));
        // Suppression: set zf=0, then blocked OPq with zero result; stalled OPq.
        step(mk(0, 1, 4'd6, 4'd0, 4'd5, 64'd7, 0, 0, 0, 0));
        step(mk(0, 1, 4'd6, 4'd1, 4'd5, 64'd0, 0, 1, 0, 0));
        step(mk(0, 1, 4'd6, 4'd1, 4'd6, 64'd0, 1, 0, 1, 0));
        // Stall+bubble holds; bubble alone loads NOP; low-bit-only zero detection.
        step(mk(0, 1, 4'd6, 4'd0, 4'd1, 64'd9, 0, 0, 1, 1));
        step(mk(0, 1, 4'd6, 4'd0, 4'd1, 64'd9, 0, 0, 0, 1));
        step(mk(0, 1, 4'd6, 4'd0, 4'd1, 64'h1_0000_0000, 0, 0, 0, 0));
        // Reset during stall.
        step(mk(0, 1, 4'd6, 4'd0, 4'd1, 64'h8000_0000_0000_0001, 1, 0, 0, 0));
        step(mk(1, 1, 4'd6, 4'd0, 4'd1, 64'd3, 0, 0, 1, 1));

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [3:0] ic;
            logic [63:0] r;
            case ($urandom_range(0, 3))
                0: ic = 4'd2;
                1: ic = 4'd6;
                2: ic = 4'd7;
                default: ic = 4'($urandom_range(0, 15));
            endcase
            r = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) r[63] = ~r[63];
            s = mk($urandom_range(0, 39) == 0, $urandom_range(0, 4) != 0, ic,
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), r,
                   1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                   $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
            s.val_a = {$urandom, $urandom};
            step(s);
        end

        repeat (3) @(posedge clk);
        #3;
        if (q_cnd.size() != 0 || q_state.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d/%0d entries left, expected 0", q_cnd.size(), q_state.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_cc_stage.md
Name: execute_cc_stage

Overview:
- Execute-stage back end of the Y86-64 pipeline. Sits directly downstream of the ALU.
- Consumes the ALU result and overflow flag, and maintains the architectural condition codes (ZF, SF, OF).
- Evaluates the jXX/cmovXX branch/move condition.
- Registers the execute results into the E/M pipeline register, with stall and bubble control.

Parameters:
- BUS_WIDTH, 64, data path width (ALU result, valA, valE).
- REG_ID_WIDTH, 4, register identifier width; all-ones (0xF) = RNONE.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- e_valid  input  1  an instruction occupies the E stage this cycle.
- e_icode  input  4  Y86 icode of the E-stage instruction.
- e_ifun  input  4  Y86 ifun (ALU op for OPq, condition for jXX/cmovXX).
- e_dst_e  input  REG_ID_WIDTH  destination register for valE.
- e_val_a  input  BUS_WIDTH  valA forwarded to M.
- alu_result  input  BUS_WIDTH  ALU output (becomes valE).
- alu_overflow  input  1  ALU signed-overflow flag (already 0 for AND/XOR).
- cc_block  input  1  exception in M/W; suppresses CC update.
- stall  input  1  hold the E/M register and CC.
- bubble  input  1  load a NOP into the E/M register.
- zf, sf, of  output  1 each  current condition-code register.
- e_cnd  output  1  combinational condition from current CC and e_ifun.
- m_valid  output  1  registered valid.
- m_icode  output  4  registered icode.
- m_cnd  output  1  registered condition.
- m_dst_e  output  REG_ID_WIDTH  registered destination (RNONE if cmov not taken).
- m_val_e  output  BUS_WIDTH  registered ALU result.
- m_val_a  output  BUS_WIDTH  registered valA.

Behaviour:
- Reset values (rst=1 at a clock edge, overrides everything):
  - zf=1, sf=0, of=0.
  - m_valid=0, m_icode=1 (INOP), m_cnd=0, m_dst_e=0xF, m_val_e=0, m_val_a=0.
- CC update:
  - Occurs at the edge iff rst=0, stall=0, e_valid=1, e_icode=6 (OPq) and cc_block=0.
  - zf <= (alu_result==0); sf <= alu_result[BUS_WIDTH-1]; of <= alu_overflow.
  - Otherwise CC holds.
- e_cnd is combinational and always uses the pre-update CC value, by e_ifun:
  - 0: 1 (always).
  - 1 le: (sf^of)|zf.
  - 2 l: sf^of.
  - 3 e: zf.
  - 4 ne: !zf.
  - 5 ge: !(sf^of).
  - 6 g: !(sf^of)&!zf.
  - 7–15: 0.
- Effective condition cnd_eff = e_cnd when e_icode is 2 (RRMOVQ/cmov) or 7 (jXX); otherwise 0.
- Effective destination dst_eff = 0xF when e_icode=2 and e_cnd=0; otherwise e_dst_e.
- E/M register, priority rst > stall > bubble > load:
  - stall=1: all m_* hold. stall and bubble together: stall wins.
  - bubble=1 (stall=0): load the reset (NOP) values.
  - e_valid=0 (no stall/bubble): load the NOP values.
  - Otherwise load:
    - m_valid=1, m_icode=e_icode, m_cnd=cnd_eff, m_dst_e=dst_eff;
    - m_val_e=alu_result, m_val_a=e_val_a.
- Latency:
  - CC and m_* become visible one cycle after the capturing edge.
  - An OPq at edge N affects e_cnd of the instruction in E from cycle N+1 onward; there is no same-cycle CC forwarding.
- Reset mid-operation: CC returns to Z=1/S=0/O=0 and the E/M register to NOP on the same edge, regardless of stall or bubble.
- Width rule: zero detection covers all BUS_WIDTH bits; sf is the MSB only.

Test Plan:
- Reset: rst=1 for 2 cycles -> zf=1, sf=0, of=0, m_icode=1, m_dst_e=0xF, m_valid=0.
- OPq flag capture:
  - OPq sub, alu_result=0 -> next cycle zf=1, sf=0, of=0.
  - alu_result=0x8000_0000_0000_0000 with alu_overflow=1 -> zf=0, sf=1, of=1.
- Condition table: preload CC (sf=1, of=0, zf=0) via OPq, then jXX with ifun 0..6 -> e_cnd = 1,1,1,0,1,0,0; m_cnd registered accordingly.
- cmov not taken: CC zf=0, e_icode=2, ifun=3, e_dst_e=3 -> m_dst_e=0xF, m_cnd=0; with zf=1 -> m_dst_e=3, m_cnd=1.
- Suppression:
  - OPq with cc_block=1 and alu_result=0 while zf=0 -> zf stays 0; m_val_e still 0.
  - OPq with stall=1 -> CC and m_* unchanged.
- Pipeline control:
  - stall=1 and bubble=1 together -> m_* hold.
  - bubble=1 alone -> m_icode=1, m_valid=0, m_val_e=0.
  - rst asserted during stall -> NOP values and CC reset on that edge.
